// File: rtl/branch_cond_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_cond_unit_pkg
// Brief    : Condition codes, flag bit indices and FSM states for the branch unit.
// Revision : 1.0
// ============================================================================
package branch_cond_unit_pkg;

    localparam logic [2:0] COND_NE     = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GE     = 3'b100;
    localparam logic [2:0] COND_LE     = 3'b101;
    localparam logic [2:0] COND_OV     = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FLAGS = 2'd1,
        ST_RESOLVE    = 2'd2,
        ST_FLUSH      = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/branch_cond_unit_cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : branch_cond_eval
// Brief    : Combinational condition-code evaluation against {N,V,Z} flags.
// Revision : 1.0
// ============================================================================
module branch_cond_eval
    import branch_cond_unit_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);

    logic w_n;
    logic w_v;
    logic w_z;

    assign w_n = flags[FLAG_N];
    assign w_v = flags[FLAG_V];
    assign w_z = flags[FLAG_Z];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NE:     taken = !w_z;
            COND_EQ:     taken = w_z;
            COND_GT:     taken = !w_z && !w_n;
            COND_LT:     taken = w_n;
            COND_GE:     taken = w_z || (!w_z && !w_n);
            COND_LE:     taken = w_n || w_z;
            COND_OV:     taken = w_v;
            COND_UNCOND: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/branch_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_cond_unit
// Brief    : Resolves conditional branches from N/V/Z flags, issues redirect
//            and flush. Optional taken/not-taken counters: BRANCH_STATS_EN.
// Revision : 1.0
// ============================================================================
module branch_cond_unit
    import branch_cond_unit_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int IMM_W        = 9,
    parameter int FLUSH_CYCLES = 2
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    input  logic [PC_W-1:0]  br_pc,
    input  logic [IMM_W-1:0] br_imm,
    input  logic [2:0]       flag_in,
    input  logic [2:0]       flag_wr,
    input  logic [2:0]       flag_wdata,
    input  logic             flag_wr_pending,
    output logic             stall,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             taken,
    output logic             flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]      stat_taken,
    output logic [15:0]      stat_not_taken
`endif
);

    localparam int             c_cnt_w      = 4;
    localparam logic [c_cnt_w-1:0] c_flush_init = c_cnt_w'(FLUSH_CYCLES);

    state_t             r_state;
    logic [2:0]         r_cond;
    logic [PC_W-1:0]    r_pc;
    logic [IMM_W-1:0]   r_imm;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_redirect_valid;
    logic [PC_W-1:0]    r_redirect_pc;
    logic               r_taken;
    logic               r_flush;

    logic               w_in_wait;
    logic [2:0]         w_eff;
    logic [2:0]         w_sel_cond;
    logic [PC_W-1:0]    w_sel_pc;
    logic [IMM_W-1:0]   w_sel_imm;
    logic [PC_W-1:0]    w_off;
    logic [PC_W-1:0]    w_target;
    logic               w_cond_taken;

    // Same-cycle flag writes bypass the flag register.
    assign w_eff      = (flag_wr & flag_wdata) | (~flag_wr & flag_in);
    assign w_in_wait  = (r_state == ST_WAIT_FLAGS);
    assign w_sel_cond = w_in_wait ? r_cond : br_cond;
    assign w_sel_pc   = w_in_wait ? r_pc   : br_pc;
    assign w_sel_imm  = w_in_wait ? r_imm  : br_imm;
    assign w_off      = {{(PC_W-IMM_W-1){w_sel_imm[IMM_W-1]}}, w_sel_imm, 1'b0};
    assign w_target   = w_sel_pc + PC_W'(2) + w_off;

    branch_cond_eval u_eval (
        .cond  (w_sel_cond),
        .flags (w_eff),
        .taken (w_cond_taken)
    );

    // The cycle that consumes a waiting branch drops stall so upstream does not replay it.
    always_comb begin
        stall = 1'b0;
        case (r_state)
            ST_IDLE:       stall = br_valid && flag_wr_pending;
            ST_WAIT_FLAGS: stall = flag_wr_pending;
            ST_RESOLVE:    stall = br_valid;
            ST_FLUSH:      stall = 1'b1;
            default:       stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_cond           <= '0;
            r_pc             <= '0;
            r_imm            <= '0;
            r_cnt            <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_taken          <= 1'b0;
            r_flush          <= 1'b0;
        end else begin
            r_redirect_valid <= 1'b0;
            r_taken          <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (br_valid && flag_wr_pending) begin
                        r_cond  <= br_cond;
                        r_pc    <= br_pc;
                        r_imm   <= br_imm;
                        r_state <= ST_WAIT_FLAGS;
                    end else if (br_valid) begin
                        r_taken          <= w_cond_taken;
                        r_redirect_valid <= w_cond_taken;
                        if (w_cond_taken) r_redirect_pc <= w_target;
                        r_state          <= ST_RESOLVE;
                    end
                end
                ST_WAIT_FLAGS: begin
                    if (!flag_wr_pending) begin
                        r_taken          <= w_cond_taken;
                        r_redirect_valid <= w_cond_taken;
                        if (w_cond_taken) r_redirect_pc <= w_target;
                        r_state          <= ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    if (r_taken) begin
                        r_flush <= 1'b1;
                        r_cnt   <= c_flush_init;
                        r_state <= ST_FLUSH;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (r_cnt <= c_cnt_w'(1)) begin
                        r_flush <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign taken          = r_taken;
    assign flush          = r_flush;

`ifdef BRANCH_STATS_EN
    logic [15:0] r_stat_taken;
    logic [15:0] r_stat_not_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_taken     <= '0;
            r_stat_not_taken <= '0;
        end else if (r_state == ST_RESOLVE) begin
            if (r_taken && (r_stat_taken != 16'hFFFF))
                r_stat_taken <= r_stat_taken + 16'd1;
            else if (!r_taken && (r_stat_not_taken != 16'hFFFF))
                r_stat_not_taken <= r_stat_not_taken + 16'd1;
        end
    end

    assign stat_taken     = r_stat_taken;
    assign stat_not_taken = r_stat_not_taken;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_cond_unit
// Brief    : Directed self-checking bench for branch_cond_unit.
// Revision : 1.0
// ============================================================================
module tb_branch_cond_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        br_valid = 1'b0;
    logic [2:0]  br_cond = 3'd0;
    logic [15:0] br_pc = 16'd0;
    logic [8:0]  br_imm = 9'd0;
    logic [2:0]  flag_in = 3'd0;
    logic [2:0]  flag_wr = 3'd0;
    logic [2:0]  flag_wdata = 3'd0;
    logic        flag_wr_pending = 1'b0;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        taken;
    logic        flush;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_taken;
    logic [15:0] stat_not_taken;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    branch_cond_unit #(.PC_W(16), .IMM_W(9), .FLUSH_CYCLES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .br_valid        (br_valid),
        .br_cond         (br_cond),
        .br_pc           (br_pc),
        .br_imm          (br_imm),
        .flag_in         (flag_in),
        .flag_wr         (flag_wr),
        .flag_wdata      (flag_wdata),
        .flag_wr_pending (flag_wr_pending),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .taken           (taken),
        .flush           (flush)
`ifdef BRANCH_STATS_EN
        ,
        .stat_taken      (stat_taken),
        .stat_not_taken  (stat_not_taken)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] c, input logic [15:0] pc, input logic [8:0] imm);
        br_valid = 1'b1;
        br_cond  = c;
        br_pc    = pc;
        br_imm   = imm;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_chk++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else n_pass++;
        n_chk++; if (redirect_valid !== 1'b0) $display("FAIL reset_rv got %b want 0", redirect_valid); else n_pass++;
        n_chk++; if (redirect_pc !== 16'h0000) $display("FAIL reset_pc got %h want 0000", redirect_pc); else n_pass++;
        n_chk++; if (taken !== 1'b0) $display("FAIL reset_taken got %b want 0", taken); else n_pass++;
        n_chk++; if (flush !== 1'b0) $display("FAIL reset_flush got %b want 0", flush); else n_pass++;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_taken_eq();
        flag_in = 3'b001;
        present(3'b001, 16'h0100, 9'd4);
        #1;
        n_chk++; if (stall !== 1'b0) $display("FAIL eq_stall got %b want 0", stall); else n_pass++;
        tick();
        br_valid = 1'b0;
        n_chk++; if (redirect_valid !== 1'b1) $display("FAIL eq_rv got %b want 1", redirect_valid); else n_pass++;
        n_chk++; if (taken !== 1'b1) $display("FAIL eq_taken got %b want 1", taken); else n_pass++;
        n_chk++; if (redirect_pc !== 16'h010A) $display("FAIL eq_pc got %h want 010a", redirect_pc); else n_pass++;
        n_chk++; if (flush !== 1'b0) $display("FAIL eq_flush_resolve got %b want 0", flush); else n_pass++;
        tick();
        n_chk++; if (flush !== 1'b1) $display("FAIL eq_flush1 got %b want 1", flush); else n_pass++;
        n_chk++; if (redirect_valid !== 1'b0) $display("FAIL eq_rv_pulse got %b want 0", redirect_valid); else n_pass++;
        n_chk++; if (stall !== 1'b1) $display("FAIL eq_flush_stall got %b want 1", stall); else n_pass++;
        tick();
        n_chk++; if (flush !== 1'b1) $display("FAIL eq_flush2 got %b want 1", flush); else n_pass++;
        tick();
        n_chk++; if (flush !== 1'b0) $display("FAIL eq_flush_end got %b want 0", flush); else n_pass++;
    endtask

    task automatic test_not_taken();
        flag_in = 3'b001;
        present(3'b000, 16'h0200, 9'd3);
        tick();
        n_chk++; if (redirect_valid !== 1'b0) $display("FAIL ne_rv got %b want 0", redirect_valid); else n_pass++;
        n_chk++; if (taken !== 1'b0) $display("FAIL ne_taken got %b want 0", taken); else n_pass++;
        n_chk++; if (redirect_pc !== 16'h010A) $display("FAIL ne_pc_hold got %h want 010a", redirect_pc); else n_pass++;
        present(3'b111, 16'hFFFE, 9'h1FF);
        #1;
        n_chk++; if (stall !== 1'b1) $display("FAIL resolve_stall got %b want 1", stall); else n_pass++;
        tick();
        n_chk++; if (flush !== 1'b0) $display("FAIL ne_noflush got %b want 0", flush); else n_pass++;
        n_chk++; if (stall !== 1'b0) $display("FAIL ne_idle_stall got %b want 0", stall); else n_pass++;
        tick();
        br_valid = 1'b0;
        n_chk++; if (redirect_valid !== 1'b1) $display("FAIL neg_rv got %b want 1", redirect_valid); else n_pass++;
        n_chk++; if (redirect_pc !== 16'hFFFE) $display("FAIL neg_pc got %h want fffe", redirect_pc); else n_pass++;
        tick(); tick(); tick();
    endtask

    task automatic test_wrap();
        present(3'b111, 16'hFFFC, 9'd1);
        tick();
        br_valid = 1'b0;
        n_chk++; if (redirect_valid !== 1'b1) $display("FAIL wrap_rv got %b want 1", redirect_valid); else n_pass++;
        n_chk++; if (redirect_pc !== 16'h0000) $display("FAIL wrap_pc got %h want 0000", redirect_pc); else n_pass++;
        tick(); tick(); tick();
    endtask

    task automatic test_idle_bypass();
        flag_in = 3'b001; flag_wr = 3'b001; flag_wdata = 3'b000;
        present(3'b001, 16'h0400, 9'd0);
        tick();
        br_valid = 1'b0; flag_wr = 3'b000;
        n_chk++; if (redirect_valid !== 1'b0) $display("FAIL byp_clear_rv got %b want 0", redirect_valid); else n_pass++;
        tick();
        flag_in = 3'b000; flag_wr = 3'b001; flag_wdata = 3'b001;
        present(3'b001, 16'h0400, 9'd0);
        tick();
        br_valid = 1'b0; flag_wr = 3'b000;
        n_chk++; if (redirect_valid !== 1'b1) $display("FAIL byp_set_rv got %b want 1", redirect_valid); else n_pass++;
        n_chk++; if (redirect_pc !== 16'h0402) $display("FAIL byp_set_pc got %h want 0402", redirect_pc); else n_pass++;
        tick(); tick(); tick();
    endtask

    task automatic test_wait_bypass();
        flag_in = 3'b000;
        flag_wr_pending = 1'b1;
        present(3'b011, 16'h0300, 9'h1FD);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (stall !== 1'b1) $display("FAIL wait_stall%0d got %b want 1", i, stall); else n_pass++;
            n_chk++; if (redirect_valid !== 1'b0) $display("FAIL wait_rv%0d got %b want 0", i, redirect_valid); else n_pass++;
            tick();
        end
        flag_wr_pending = 1'b0; flag_wr = 3'b100; flag_wdata = 3'b100;
        tick();
        br_valid = 1'b0; flag_wr = 3'b000; flag_wdata = 3'b000;
        n_chk++; if (redirect_valid !== 1'b1) $display("FAIL wait_rv got %b want 1", redirect_valid); else n_pass++;
        n_chk++; if (taken !== 1'b1) $display("FAIL wait_taken got %b want 1", taken); else n_pass++;
        n_chk++; if (redirect_pc !== 16'h02FC) $display("FAIL wait_pc got %h want 02fc", redirect_pc); else n_pass++;
        tick(); tick(); tick();
    endtask

    task automatic test_conds();
        logic [2:0] t_cond [10] = '{3'b000, 3'b001, 3'b010, 3'b010, 3'b011, 3'b100, 3'b100, 3'b101, 3'b110, 3'b110};
        logic [2:0] t_flag [10] = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b100, 3'b001, 3'b100, 3'b000, 3'b010, 3'b101};
        logic       t_exp  [10] = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b1,   1'b1,   1'b0,   1'b0,   1'b1,   1'b0};
        for (int i = 0; i < 10; i++) begin
            flag_in = t_flag[i];
            present(t_cond[i], 16'h1000, 9'd8);
            tick();
            br_valid = 1'b0;
            n_chk++; if (taken !== t_exp[i]) $display("FAIL cond%0d taken got %b want %b", i, taken, t_exp[i]); else n_pass++;
            tick(); tick(); tick();
        end
    endtask

    task automatic test_async_reset();
        flag_in = 3'b000;
        flag_wr_pending = 1'b1;
        present(3'b111, 16'h0500, 9'd2);
        tick();
        br_valid = 1'b0;
        #1;
        n_chk++; if (stall !== 1'b1) $display("FAIL ar_wait_stall got %b want 1", stall); else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++; if (stall !== 1'b0) $display("FAIL ar_wait_stall_rst got %b want 0", stall); else n_pass++;
        n_chk++; if (redirect_valid !== 1'b0) $display("FAIL ar_wait_rv got %b want 0", redirect_valid); else n_pass++;
        tick();
        flag_wr_pending = 1'b0;
        rst = 1'b0;
        present(3'b111, 16'h0600, 9'd0);
        #1;
        n_chk++; if (stall !== 1'b0) $display("FAIL ar_accept_stall got %b want 0", stall); else n_pass++;
        n_chk++; if (redirect_valid !== 1'b0) $display("FAIL ar_no_redirect got %b want 0", redirect_valid); else n_pass++;
        tick();
        br_valid = 1'b0;
        n_chk++; if (redirect_pc !== 16'h0602) $display("FAIL ar_new_pc got %h want 0602", redirect_pc); else n_pass++;
        tick();
        n_chk++; if (flush !== 1'b1) $display("FAIL ar_flush_pre got %b want 1", flush); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_chk++; if (flush !== 1'b0) $display("FAIL ar_flush_rst got %b want 0", flush); else n_pass++;
        n_chk++; if (stall !== 1'b0) $display("FAIL ar_flush_stall got %b want 0", stall); else n_pass++;
        n_chk++; if (redirect_pc !== 16'h0000) $display("FAIL ar_flush_pc got %h want 0000", redirect_pc); else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        n_chk++; if (flush !== 1'b0) $display("FAIL ar_post_flush got %b want 0", flush); else n_pass++;
        n_chk++; if (redirect_valid !== 1'b0) $display("FAIL ar_post_rv got %b want 0", redirect_valid); else n_pass++;
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        logic [2:0] s_cond [5] = '{3'b001, 3'b011, 3'b010, 3'b101, 3'b110};
        logic [2:0] s_flag [5] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b010};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++; if (stat_taken !== 16'd0) $display("FAIL stat_taken_rst got %0d want 0", stat_taken); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            flag_in = s_flag[i];
            present(s_cond[i], 16'h2000, 9'd1);
            tick();
            br_valid = 1'b0;
            tick(); tick(); tick();
        end
        n_chk++; if (stat_taken !== 16'd3) $display("FAIL stat_taken got %0d want 3", stat_taken); else n_pass++;
        n_chk++; if (stat_not_taken !== 16'd2) $display("FAIL stat_not_taken got %0d want 2", stat_not_taken); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_taken_eq();
        test_not_taken();
        test_wrap();
        test_idle_bypass();
        test_wait_bypass();
        test_conds();
        test_async_reset();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
